// File: rtl/servo_track_sched_pkg.sv
// Shared types, default angle limits and saturating angle arithmetic for the
// gimbal scheduler.
package servo_sched_pkg;

    // Encodings double as the externally visible mode code.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HOME  = 3'd1,
        ST_SCAN  = 3'd2,
        ST_TRACK = 3'd3,
        ST_LOST  = 3'd4
    } state_e;

    localparam int unsigned DEF_ANGLE_MIN  = 25000;
    localparam int unsigned DEF_ANGLE_MAX  = 125000;
    localparam int unsigned DEF_ANGLE_HOME = 75000;

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] step,
                                            input logic [31:0] hi);
        if (a > hi - step) return hi;
        return a + step;
    endfunction

    // Compare before subtracting so the word can never wrap below the floor.
    function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                            input logic [31:0] step,
                                            input logic [31:0] lo);
        if (a < lo + step) return lo;
        return a - step;
    endfunction

    function automatic logic [31:0] move_toward(input logic [31:0] a,
                                                input logic [31:0] tgt,
                                                input logic [31:0] step);
        if (a < tgt) return (tgt - a <= step) ? tgt : a + step;
        if (a > tgt) return (a - tgt <= step) ? tgt : a - step;
        return tgt;
    endfunction

endpackage

// File: rtl/servo_track_sched_if.sv
// Vision/control side to gimbal scheduler bus: centroid capture in, angle words and mode out.
interface servo_track_sched_if;
    logic        sw_en;
    logic        target_valid;
    logic [11:0] cen_x;
    logic [11:0] cen_y;
    logic [31:0] angle_x;
    logic [31:0] angle_y;
    logic [2:0]  mode;
    logic        locked;

    modport master (
        output sw_en, target_valid, cen_x, cen_y,
        input  angle_x, angle_y, mode, locked
    );

    modport slave (
        input  sw_en, target_valid, cen_x, cen_y,
        output angle_x, angle_y, mode, locked
    );
endinterface

// File: rtl/servo_tick_gen.sv
// Free-running update-tick divider: one-cycle tick_o every TICK_DIV clk_servo cycles.
module servo_tick_gen #(
    parameter int unsigned TICK_DIV = 25000
) (
    input  logic clk_servo,
    input  logic rst,
    output logic tick_o
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        tick_o  = (count_q == CW'(TICK_DIV - 1));
        count_d = tick_o ? '0 : count_q + CW'(1);
    end

    always_ff @(posedge clk_servo or negedge rst) begin
        if (!rst) count_q <= '0;
        else      count_q <= count_d;
    end

endmodule

// File: rtl/servo_track_sched.sv
// Pan/tilt gimbal mode scheduler (IDLE/HOME/SCAN/TRACK/LOST) driving PWM angle words.
// Optional feature: define SERVO_SCHED_PROP_STEP_EN for double steps on far-off centroids.
module servo_track_sched
    import servo_sched_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 25000,
    parameter int unsigned ANGLE_MIN  = DEF_ANGLE_MIN,
    parameter int unsigned ANGLE_MAX  = DEF_ANGLE_MAX,
    parameter int unsigned ANGLE_HOME = DEF_ANGLE_HOME,
    parameter int unsigned STEP       = 778,
    parameter int unsigned SCAN_STEP  = 1556,
    parameter int unsigned LOST_TICKS = 64,
    parameter int unsigned X_LO       = 270,
    parameter int unsigned X_HI       = 370,
    parameter int unsigned Y_LO       = 190,
    parameter int unsigned Y_HI       = 290
) (
    input  logic                clk_servo,
    input  logic                rst,
    servo_track_sched_if.slave  bus
);

    localparam int unsigned MW = $clog2(LOST_TICKS) + 1;

    logic           tick;
    state_e         state_q, state_d;
    logic [31:0]    ax_q, ax_d, ay_q, ay_d;
    logic           fresh_q, fresh_d;
    logic [11:0]    cx_q, cx_d, cy_q, cy_d;
    logic [MW-1:0]  miss_q, miss_d;
    logic           dir_up_q, dir_up_d;
    logic [31:0]    cx_w, cy_w;
    logic [31:0]    step_x, step_y;

    servo_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_servo (clk_servo),
        .rst       (rst),
        .tick_o    (tick)
    );

    assign cx_w = {20'd0, cx_q};
    assign cy_w = {20'd0, cy_q};

`ifdef SERVO_SCHED_PROP_STEP_EN
    logic far_x, far_y;
    assign far_x = ((X_LO >= 100) && (cx_w < X_LO - 100)) || (cx_w > X_HI + 100);
    assign far_y = ((Y_LO >= 100) && (cy_w < Y_LO - 100)) || (cy_w > Y_HI + 100);
    assign step_x = far_x ? 32'(2 * STEP) : STEP;
    assign step_y = far_y ? 32'(2 * STEP) : STEP;
`else
    assign step_x = STEP;
    assign step_y = STEP;
`endif

    // A new centroid wins over the tick clearing fresh, so coincident data survives.
    always_comb begin
        fresh_d = fresh_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        if (bus.target_valid) begin
            fresh_d = 1'b1;
            cx_d    = bus.cen_x;
            cy_d    = bus.cen_y;
        end else if (tick && bus.sw_en) begin
            fresh_d = 1'b0;
        end
    end

    always_ff @(posedge clk_servo or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            ax_q     <= ANGLE_HOME;
            ay_q     <= ANGLE_HOME;
            fresh_q  <= 1'b0;
            cx_q     <= '0;
            cy_q     <= '0;
            miss_q   <= '0;
            dir_up_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            ax_q     <= ax_d;
            ay_q     <= ay_d;
            fresh_q  <= fresh_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            miss_q   <= miss_d;
            dir_up_q <= dir_up_d;
        end
    end

    // Disable overrides everything, including a tick landing in the same cycle.
    always_comb begin
        state_d  = state_q;
        ax_d     = ax_q;
        ay_d     = ay_q;
        miss_d   = miss_q;
        dir_up_d = dir_up_q;
        if (!bus.sw_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_HOME;
                ST_HOME: if (tick) begin
                    ax_d = move_toward(ax_q, ANGLE_HOME, SCAN_STEP);
                    ay_d = move_toward(ay_q, ANGLE_HOME, SCAN_STEP);
                    if (ax_d == ANGLE_HOME && ay_d == ANGLE_HOME) state_d = ST_SCAN;
                end
                ST_SCAN: if (tick) begin
                    if (fresh_q) begin
                        state_d = ST_TRACK;
                    end else if (dir_up_q) begin
                        ax_d = sat_add(ax_q, SCAN_STEP, ANGLE_MAX);
                        if (ax_d == ANGLE_MAX) dir_up_d = 1'b0;
                    end else begin
                        ax_d = sat_sub(ax_q, SCAN_STEP, ANGLE_MIN);
                        if (ax_d == ANGLE_MIN) dir_up_d = 1'b1;
                    end
                end
                ST_TRACK: if (tick) begin
                    if (fresh_q) begin
                        // Image y grows downward, so a high target raises tilt.
                        if (cy_w <= Y_LO)      ay_d = sat_add(ay_q, step_y, ANGLE_MAX);
                        else if (cy_w >= Y_HI) ay_d = sat_sub(ay_q, step_y, ANGLE_MIN);
                        if (cx_w <= X_LO)      ax_d = sat_sub(ax_q, step_x, ANGLE_MIN);
                        else if (cx_w >= X_HI) ax_d = sat_add(ax_q, step_x, ANGLE_MAX);
                    end else begin
                        state_d = ST_LOST;
                        miss_d  = '0;
                    end
                end
                ST_LOST: if (tick) begin
                    if (fresh_q) begin
                        state_d = ST_TRACK;
                        miss_d  = '0;
                    end else begin
                        miss_d = miss_q + MW'(1);
                        if (miss_q == MW'(LOST_TICKS - 1)) state_d = ST_SCAN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.mode    = state_q;
        bus.locked  = (state_q == ST_TRACK);
        bus.angle_x = ax_q;
        bus.angle_y = ay_q;
    end

endmodule

// File: tb/tb_servo_track_sched.sv
// Directed bench for servo_track_sched with TICK_DIV=4, LOST_TICKS=4.
module tb_servo_track_sched;

    localparam logic [31:0] HOME = 32'd75000;
    localparam logic [31:0] AMAX = 32'd125000;
    localparam logic [31:0] STP  = 32'd778;
    localparam logic [31:0] SSTP = 32'd1556;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    int   p           = 0;
    logic [31:0] exp_x, exp_y;

    always #5 clk = ~clk;

    servo_track_sched_if bus();

    servo_track_sched #(.TICK_DIV(4), .LOST_TICKS(4)) dut (
        .clk_servo (clk),
        .rst       (rst_n),
        .bus       (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] ex, input logic [31:0] ey, input int m);
        check({tag, ".ax"},     bus.angle_x,      ex);
        check({tag, ".ay"},     bus.angle_y,      ey);
        check({tag, ".mode"},   32'(bus.mode),    32'(m));
        check({tag, ".locked"}, 32'(bus.locked),  (m == 3) ? 32'd1 : 32'd0);
    endtask

    // p counts rising edges since reset release; updates land on multiples of 4.
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        p += n;
    endtask

    task automatic to_tick();
        cycles(4 - (p % 4));
    endtask

    task automatic pulse(input int x, input int y);
        bus.target_valid = 1'b1;
        bus.cen_x        = 12'(x);
        bus.cen_y        = 12'(y);
        cycles(1);
        bus.target_valid = 1'b0;
    endtask

    initial begin
        bus.sw_en        = 1'b0;
        bus.target_valid = 1'b0;
        bus.cen_x        = '0;
        bus.cen_y        = '0;
        repeat (2) @(negedge clk);
        check_all("reset", HOME, HOME, 0);
        rst_n = 1'b1;
        p     = 0;
        cycles(10);
        check_all("idle_hold", HOME, HOME, 0);

        bus.sw_en = 1'b1;
        cycles(1);
        check("home_mode", 32'(bus.mode), 32'd1);
        to_tick();
        check_all("scan_entry", HOME, HOME, 2);

        for (int k = 1; k <= 34; k++) begin
            to_tick();
            if (k <= 32)      exp_x = HOME + SSTP * k;
            else if (k == 33) exp_x = AMAX;
            else              exp_x = AMAX - SSTP;
            if (k <= 2 || k >= 32) check_all($sformatf("scan%0d", k), exp_x, HOME, 2);
        end

        pulse(320, 100); to_tick();
        check_all("acquire", 32'd123444, HOME, 3);
        pulse(320, 100); to_tick();
        check_all("track_up", 32'd123444, 32'd75778, 3);
        pulse(270, 190); to_tick();
        check_all("track_lo_edges", 32'd122666, 32'd76556, 3);
        pulse(370, 290); to_tick();
        check_all("track_hi_edges", 32'd123444, 32'd75778, 3);
        pulse(200, 240); to_tick();
        check_all("track_left", 32'd122666, 32'd75778, 3);

        to_tick();
        check_all("lost_entry", 32'd122666, 32'd75778, 4);
        for (int k = 1; k <= 3; k++) begin
            to_tick();
            check_all($sformatf("lost_hold%0d", k), 32'd122666, 32'd75778, 4);
        end
        to_tick();
        check_all("lost_to_scan", 32'd122666, 32'd75778, 2);
        pulse(320, 240); to_tick();
        check_all("reacquire", 32'd122666, 32'd75778, 3);
        to_tick();
        check_all("lost_again", 32'd122666, 32'd75778, 4);
        pulse(320, 240); to_tick();
        check_all("lost_recover", 32'd122666, 32'd75778, 3);

        pulse(100, 50); to_tick();
`ifdef SERVO_SCHED_PROP_STEP_EN
        exp_x = 32'd121110; exp_y = 32'd77334;
`else
        exp_x = 32'd121888; exp_y = 32'd76556;
`endif
        check_all("far_target", exp_x, exp_y, 3);

        // Second pulse is captured on the tick edge itself and must wait a tick.
        pulse(320, 240); cycles(2); pulse(320, 100);
        check_all("coinc_hold", exp_x, exp_y, 3);
        to_tick();
        exp_y = exp_y + STP;
        check_all("coinc_apply", exp_x, exp_y, 3);

        for (int k = 0; k < 80 && exp_y < AMAX; k++) begin
            pulse(320, 100); to_tick();
            exp_y = (exp_y + STP > AMAX) ? AMAX : exp_y + STP;
            check_all("clamp_up", exp_x, exp_y, 3);
        end
        pulse(320, 100); to_tick();
        check_all("clamp_hold", exp_x, AMAX, 3);

        pulse(320, 300); cycles(2);
        bus.sw_en = 1'b0;
        cycles(1);
        check_all("disable", exp_x, AMAX, 0);
        cycles(8);
        check_all("idle_frozen", exp_x, AMAX, 0);

        bus.sw_en = 1'b1;
        cycles(1);
        check("rehome_mode", 32'(bus.mode), 32'd1);
        to_tick();
        check_all("home_slew", exp_x - SSTP, AMAX - SSTP, 1);

        #2 rst_n = 1'b0;
        #1 check_all("async_rst", HOME, HOME, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/servo_track_sched.md
# servo_track_sched

Pan/tilt gimbal mode scheduler for the camera servo path. Consumes per-frame target centroids from the vision pipeline, sequences the gimbal through home, scan, track and lost-target recovery, and drives the pan/tilt angle words into the two downstream PWM generators. All angle words are in PWM-clock counts.

## Interface
- `TICK_DIV`, 25000: clk_servo cycles per update tick.
- `ANGLE_MIN`, 25000: lower clamp.
- `ANGLE_MAX`, 125000: upper clamp.
- `ANGLE_HOME`, 75000: reset and home position.
- `STEP`, 778: tracking step per tick.
- `SCAN_STEP`, 1556: scan and home slew step per tick.
- `LOST_TICKS`, 64: number of ticks without a target before LOST returns to SCAN.
- `X_LO`/`X_HI`, 270/370: pan deadband, pixels.
- `Y_LO`/`Y_HI`, 190/290: tilt deadband, pixels.
- `clk_servo` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `sw_en` in 1: gimbal enable.
- `target_valid` in 1: one-cycle pulse; `cen_x`/`cen_y` valid.
- `cen_x` in 12: target centroid x.
- `cen_y` in 12: target centroid y.
- `angle_x` out 32: pan angle word.
- `angle_y` out 32: tilt angle word.
- `mode` out 3: state code. IDLE=0, HOME=1, SCAN=2, TRACK=3, LOST=4.
- `locked` out 1: high when in TRACK.

## Operation
- **Reset values:** `angle_x` = `angle_y` = ANGLE_HOME; `mode` = IDLE; `locked` = 0. The tick counter, `fresh` flag, miss counter and scan direction are all cleared. Scan direction resets to "up".
- **Capture:** `target_valid` latches `cen_x`/`cen_y` and sets `fresh`, in every state.
- **Tick consumption:** each tick consumes the pre-tick `fresh` and centroid values, then clears `fresh`. If `target_valid` coincides with a tick, its data is kept, `fresh` stays set, and it is used on the next tick.
- **Any state, `sw_en`=0:**
  - Go to IDLE on the next cycle.
  - Angles are frozen.
  - The tick counter keeps running.
- **IDLE:** when `sw_en`=1, go to HOME.
- **HOME, each tick:**
  - Move each axis toward ANGLE_HOME by SCAN_STEP, landing exactly on ANGLE_HOME when within one step.
  - When both axes equal ANGLE_HOME after the update, go to SCAN.
  - `fresh` is ignored.
- **SCAN, each tick:**
  - If `fresh`, go to TRACK with no angle change.
  - Otherwise `angle_x` moves ±SCAN_STEP, saturating at the limits.
  - On reaching ANGLE_MAX or ANGLE_MIN, the direction flips.
  - `angle_y` is held.
- **TRACK, each tick:**
  - If `fresh`:
    - `cen_y` ≤ Y_LO: `angle_y` += STEP. `cen_y` ≥ Y_HI: `angle_y` -= STEP.
    - `cen_x` ≤ X_LO: `angle_x` -= STEP. `cen_x` ≥ X_HI: `angle_x` += STEP.
    - Inside the deadband: hold.
  - If not `fresh`: go to LOST with miss counter = 0.
- **LOST, each tick:**
  - Angles are held.
  - If `fresh`: go to TRACK and clear the miss counter (no step this tick).
  - Otherwise increment the miss counter. At LOST_TICKS-1, go to SCAN.
- **Arithmetic:**
  - 32-bit unsigned with saturating clamp to [ANGLE_MIN, ANGLE_MAX].
  - Subtraction checks `angle < ANGLE_MIN + step` before subtracting, so there is no underflow wrap.
  - Angles never leave the clamp range.

## Timing
- The tick is a one-cycle pulse when the counter equals TICK_DIV-1. The counter then wraps to 0.
- Angle and state updates are registered. They are visible the cycle after the tick cycle.
- `mode`/`locked` are registered from the state and change together with it.
- Capture latency: a `target_valid` at cycle n is consumable by any tick at cycle ≥ n+1.
- `sw_en` falling acts on the next cycle regardless of the tick. A tick in that same cycle is discarded.
- `rst` asserted mid-operation returns all outputs to their reset values immediately (asynchronously).

## Configuration
- `SERVO_SCHED_PROP_STEP_EN`
  - **Defined:** in TRACK, a centroid more than 100 px outside its deadband steps by 2×STEP instead of STEP. The y outer thresholds are `cen_y` < Y_LO-100 and `cen_y` > Y_HI+100; x uses the same rule. Clamping still applies.
  - **Undefined:** the step is always STEP.

## Structure
- `servo_sched_pkg` holds:
  - the state enum and mode codes;
  - default angle constants ANGLE_MIN/MAX/HOME;
  - the saturating add/sub functions.
- Sub-module `servo_tick_gen` contains the TICK_DIV counter and the one-cycle `tick` output. It uses the same clock and reset.

## Test plan
All tests use TICK_DIV=4 and LOST_TICKS=4.
- **Reset:** `angle_x`/`angle_y` = 75000, `mode`=0, `locked`=0. Holding `sw_en`=0 keeps these values forever.
- **Home and scan:** `sw_en`=1 → HOME, then SCAN on the first tick. `angle_x` goes 76556, 78112, … → saturates at 125000, then decrements by 1556. `angle_y` stays 75000.
- **Acquire and track:** in SCAN, pulse `target_valid` with `cen_x`=320, `cen_y`=100 → TRACK on the next tick with no step. Pulse again → the next tick gives `angle_y` +778 and `angle_x` unchanged.
- **Lost target:** in TRACK, stop the pulses → LOST on the next tick, then SCAN after 4 more ticks, with angles held throughout LOST. A pulse during LOST → back to TRACK.
- **Clamp:** with `angle_y`=124800 in TRACK and `cen_y`=100 → `angle_y` = 125000. A further pulse keeps it at 125000.
- **Disable and macro:**
  - `sw_en`→0 mid-TRACK → `mode`=0 the next cycle, angles frozen.
  - With `SERVO_SCHED_PROP_STEP_EN` defined, `cen_y`=50 → +1556.
  - `target_valid` coincident with a tick → applied on the following tick.
